// File: rtl/kbd_lcd_ctrl.sv
// PS/2 set-2 scan-code decoder, ASCII queue and HD44780 16x2 LCD write sequencer.
// Runs the LCD power-up init, then writes queued characters with cursor wrap and line change.
module kbd_lcd_ctrl #(
  parameter int EN_CYCLES       = 25,
  parameter int CMD_WAIT_CYCLES = 2500,
  parameter int CLR_WAIT_CYCLES = 100000,
  parameter int PWRUP_CYCLES    = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       busy,
  output logic       drop
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] ENTER_TOK = 8'h0A;

  typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_DISPATCH, S_SETUP, S_EN_HI, S_WAIT} state_t;

  function automatic logic [8:0] decode(input logic [7:0] code);
    logic [8:0] r;
    r = 9'd0;
    case (code)
      8'h1C: r = {1'b1, 8'h41}; 8'h32: r = {1'b1, 8'h42}; 8'h21: r = {1'b1, 8'h43};
      8'h23: r = {1'b1, 8'h44}; 8'h24: r = {1'b1, 8'h45}; 8'h2B: r = {1'b1, 8'h46};
      8'h34: r = {1'b1, 8'h47}; 8'h33: r = {1'b1, 8'h48}; 8'h43: r = {1'b1, 8'h49};
      8'h3B: r = {1'b1, 8'h4A}; 8'h42: r = {1'b1, 8'h4B}; 8'h4B: r = {1'b1, 8'h4C};
      8'h3A: r = {1'b1, 8'h4D}; 8'h31: r = {1'b1, 8'h4E}; 8'h44: r = {1'b1, 8'h4F};
      8'h4D: r = {1'b1, 8'h50}; 8'h15: r = {1'b1, 8'h51}; 8'h2D: r = {1'b1, 8'h52};
      8'h1B: r = {1'b1, 8'h53}; 8'h2C: r = {1'b1, 8'h54}; 8'h3C: r = {1'b1, 8'h55};
      8'h2A: r = {1'b1, 8'h56}; 8'h1D: r = {1'b1, 8'h57}; 8'h22: r = {1'b1, 8'h58};
      8'h35: r = {1'b1, 8'h59}; 8'h1A: r = {1'b1, 8'h5A};
      8'h45: r = {1'b1, 8'h30}; 8'h16: r = {1'b1, 8'h31}; 8'h1E: r = {1'b1, 8'h32};
      8'h26: r = {1'b1, 8'h33}; 8'h25: r = {1'b1, 8'h34}; 8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36}; 8'h3D: r = {1'b1, 8'h37}; 8'h3E: r = {1'b1, 8'h38};
      8'h46: r = {1'b1, 8'h39};
      8'h29: r = {1'b1, 8'h20};
      8'h5A: r = {1'b1, ENTER_TOK};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // ---------------- decoder ----------------
  logic       brk_reg, ext_reg, dec_valid_reg;
  logic [7:0] dec_char_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_reg       <= 1'b0;
      ext_reg       <= 1'b0;
      dec_valid_reg <= 1'b0;
      dec_char_reg  <= 8'h00;
    end else begin
      dec_valid_reg <= 1'b0;
      if (scan_valid) begin
        // A byte following F0 or E0 is swallowed whatever it is.
        if (brk_reg)                brk_reg <= 1'b0;
        else if (ext_reg)           ext_reg <= 1'b0;
        else if (scan_code == 8'hF0) brk_reg <= 1'b1;
        else if (scan_code == 8'hE0) ext_reg <= 1'b1;
        else {dec_valid_reg, dec_char_reg} <= decode(scan_code);
      end
    end
  end

  // ---------------- ASCII FIFO ----------------
  logic [7:0]     mem [FIFO_DEPTH];
  logic [7:0]     rd_data_reg;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0] count_reg;
  logic           drop_reg, full, push_ok, pop;
  state_t         state_reg;

  assign full    = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign push_ok = dec_valid_reg && !full;
  assign pop     = (state_reg == S_IDLE) && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= dec_char_reg;
    if (pop)     rd_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= 1'b0;
    end else begin
      drop_reg <= dec_valid_reg && full;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- LCD write sequencer ----------------
  logic [31:0] cnt_reg;
  logic [1:0]  init_idx_reg;
  logic        in_init_reg, pend_valid_reg;
  logic [7:0]  pend_cmd_reg, lcd_data_reg;
  logic [4:0]  cursor_reg;
  logic        lcd_rs_reg, lcd_en_reg, lcd_on_reg;
  logic [31:0] wait_last;

  assign wait_last = (!lcd_rs_reg && lcd_data_reg == 8'h01) ? 32'(CLR_WAIT_CYCLES - 1)
                                                            : 32'(CMD_WAIT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_PWRUP;
      cnt_reg        <= '0;
      init_idx_reg   <= '0;
      in_init_reg    <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_cmd_reg   <= 8'h00;
      cursor_reg     <= '0;
      lcd_data_reg   <= 8'h00;
      lcd_rs_reg     <= 1'b0;
      lcd_en_reg     <= 1'b0;
      lcd_on_reg     <= 1'b0;
    end else begin
      lcd_on_reg <= 1'b1;
      case (state_reg)
        S_PWRUP: begin
          if (cnt_reg == 32'(PWRUP_CYCLES - 1)) begin
            cnt_reg      <= '0;
            in_init_reg  <= 1'b1;
            init_idx_reg <= 2'd0;
            lcd_data_reg <= init_byte(2'd0);
            lcd_rs_reg   <= 1'b0;
            state_reg    <= S_SETUP;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        S_IDLE: if (pop) state_reg <= S_DISPATCH;
        S_DISPATCH: begin
          state_reg <= S_SETUP;
          if (rd_data_reg == ENTER_TOK) begin
            lcd_rs_reg   <= 1'b0;
            lcd_data_reg <= cursor_reg[4] ? 8'h01 : 8'hC0;
            cursor_reg   <= cursor_reg[4] ? 5'd0 : 5'd16;
          end else begin
            lcd_rs_reg   <= 1'b1;
            lcd_data_reg <= rd_data_reg;
            cursor_reg   <= cursor_reg + 5'd1;  // 31 wraps to 0 with the clear below
            if (cursor_reg == 5'd15 || cursor_reg == 5'd31) begin
              pend_valid_reg <= 1'b1;
              pend_cmd_reg   <= cursor_reg[4] ? 8'h01 : 8'hC0;
            end
          end
        end
        S_SETUP: begin
          lcd_en_reg <= 1'b1;
          cnt_reg    <= '0;
          state_reg  <= S_EN_HI;
        end
        S_EN_HI: begin
          if (cnt_reg == 32'(EN_CYCLES - 1)) begin
            lcd_en_reg <= 1'b0;
            cnt_reg    <= '0;
            state_reg  <= S_WAIT;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        S_WAIT: begin
          if (cnt_reg == wait_last) begin
            cnt_reg <= '0;
            if (in_init_reg) begin
              if (init_idx_reg == 2'd3) begin
                in_init_reg <= 1'b0;
                state_reg   <= S_IDLE;
              end else begin
                init_idx_reg <= init_idx_reg + 2'd1;
                lcd_data_reg <= init_byte(init_idx_reg + 2'd1);
                state_reg    <= S_SETUP;
              end
            end else if (pend_valid_reg) begin
              pend_valid_reg <= 1'b0;
              lcd_data_reg   <= pend_cmd_reg;
              lcd_rs_reg     <= 1'b0;
              state_reg      <= S_SETUP;
            end else begin
              state_reg <= S_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        default: state_reg <= S_PWRUP;
      endcase
    end
  end

  assign lcd_data = lcd_data_reg;
  assign lcd_rs   = lcd_rs_reg;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_reg;
  assign lcd_on   = lcd_on_reg;
  assign busy     = (state_reg != S_IDLE) || (count_reg != '0);
  assign drop     = drop_reg;

endmodule

// File: tb/tb_kbd_lcd_ctrl.sv
// Scoreboard bench for kbd_lcd_ctrl: expected LCD writes are queued as keys are sent
// and compared when each E pulse starts.
module tb_kbd_lcd_ctrl;

  localparam int EN = 2, CMD = 4, CLR = 8, PWRUP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, busy, drop;

  kbd_lcd_ctrl #(
    .EN_CYCLES(EN), .CMD_WAIT_CYCLES(CMD), .CLR_WAIT_CYCLES(CLR),
    .PWRUP_CYCLES(PWRUP), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;   // expected low cycles since the previous E pulse, 0 = unchecked
  } wr_t;

  wr_t sb[$];
  int  n_cmp = 0, n_err = 0;
  int  model_cursor = 0;
  int  drop_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------- monitor ----------
  logic prev_en = 1'b0;
  bit   have_fall = 1'b0;
  int   width = 0, low_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0; have_fall = 1'b0; width = 0; low_cnt = 0;
    end else begin
      if (drop) drop_cnt++;
      if (lcd_en && !prev_en) begin
        width = 1;
        if (sb.size() == 0) begin
          check_val("extra_write", {23'd0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check_val("wr_rs", 32'(lcd_rs), 32'(e.rs));
          check_val("wr_data", 32'(lcd_data), 32'(e.data));
          if (e.gap != 0 && have_fall) check_val("wr_gap", low_cnt, e.gap);
          $display("write rs=%0d data=0x%02h", lcd_rs, lcd_data);
        end
      end else if (lcd_en) begin
        width++;
      end else if (prev_en) begin
        check_val("en_width", width, EN);
        have_fall = 1'b1;
        low_cnt = 1;
      end else if (have_fall) begin
        low_cnt++;
      end
      prev_en = lcd_en;
    end
  end

  // ---------- model ----------
  task automatic exp_push(input logic rs, input logic [7:0] d, input int gap);
    wr_t e;
    e.rs = rs; e.data = d; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic model_char(input logic [7:0] c);
    exp_push(1'b1, c, 0);
    model_cursor++;
    if (model_cursor == 16) exp_push(1'b0, 8'hC0, CMD + 1);
    if (model_cursor == 32) begin
      exp_push(1'b0, 8'h01, CMD + 1);
      model_cursor = 0;
    end
  endtask

  task automatic model_enter();
    if (model_cursor < 16) begin
      exp_push(1'b0, 8'hC0, 0); model_cursor = 16;
    end else begin
      exp_push(1'b0, 8'h01, 0); model_cursor = 0;
    end
  endtask

  task automatic send_code(input logic [7:0] code);
    @(negedge clk);
    scan_code = code; scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    repeat (8) @(negedge clk);
    while ((busy || sb.size() != 0) && k < 3000) begin
      @(negedge clk); k++;
    end
    if (k >= 3000) begin
      check_val("idle_timeout_busy", 32'(busy), 32'd0);
      check_val("idle_timeout_sb", sb.size(), 0);
    end
  endtask

  // Reset, optionally firing a burst of six make codes during power-up.
  task automatic do_reset(input bit burst);
    int k;
    rst_n = 1'b0;
    sb.delete();
    model_cursor = 0;
    repeat (2) @(negedge clk);
    exp_push(1'b0, 8'h38, 0);
    exp_push(1'b0, 8'h0C, CMD + 1);
    exp_push(1'b0, 8'h01, CMD + 1);
    exp_push(1'b0, 8'h06, CLR + 1);
    if (burst) begin
      model_char(8'h41); model_char(8'h42); model_char(8'h43); model_char(8'h44);
    end
    rst_n = 1'b1;
    k = 0;
    fork
      begin
        // PWRUP cycles plus the one SETUP cycle before lcd_en rises
        @(negedge clk); k++;
        check_val("lcd_on_after_rst", 32'(lcd_on), 32'd1);
        while (!lcd_en && k < 50) begin @(negedge clk); k++; end
        check_val("pwrup_len", k, PWRUP + 1);
      end
      begin
        if (burst) begin
          send_code(8'h1C); send_code(8'h32); send_code(8'h21);
          send_code(8'h23); send_code(8'h24); send_code(8'h2B);
        end
      end
    join
    wait_idle();
    check_val("busy_after_init", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0, k;
    // reset state
    repeat (3) @(negedge clk);
    check_val("rst_data", 32'(lcd_data), 32'd0);
    check_val("rst_rs", 32'(lcd_rs), 32'd0);
    check_val("rst_rw", 32'(lcd_rw), 32'd0);
    check_val("rst_en", 32'(lcd_en), 32'd0);
    check_val("rst_on", 32'(lcd_on), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd1);
    check_val("rst_drop", 32'(drop), 32'd0);

    do_reset(1'b0);

    // single key, break and extended prefixes
    model_char(8'h41); send_code(8'h1C); wait_idle();
    send_code(8'hF0); send_code(8'h1C); wait_idle();
    send_code(8'hE0); send_code(8'h75); wait_idle();
    send_code(8'h07); wait_idle();
    model_char(8'h41); send_code(8'h1C); wait_idle();
    model_char(8'h20); send_code(8'h29); wait_idle();
    model_char(8'h5A); send_code(8'h1A); wait_idle();
    model_char(8'h39); send_code(8'h46); wait_idle();

    // line wrap and screen wrap
    do_reset(1'b0);
    for (int i = 0; i < 33; i++) begin
      model_char(8'h31); send_code(8'h16); wait_idle();
    end
    for (int i = 0; i < 15; i++) begin
      model_char(8'h30); send_code(8'h45); wait_idle();
    end
    check_val("sb_after_wrap", sb.size(), 0);

    // ENTER on each line
    do_reset(1'b0);
    model_char(8'h42); send_code(8'h32); wait_idle();
    model_char(8'h43); send_code(8'h21); wait_idle();
    model_char(8'h44); send_code(8'h23); wait_idle();
    model_enter(); send_code(8'h5A); wait_idle();
    model_char(8'h45); send_code(8'h24); wait_idle();
    model_enter(); send_code(8'h5A); wait_idle();
    model_enter(); send_code(8'h5A); wait_idle();

    // FIFO overflow during power-up
    d0 = drop_cnt;
    do_reset(1'b1);
    check_val("drop_pulses", drop_cnt - d0, 2);

    // reset in the middle of an E pulse
    model_char(8'h41); send_code(8'h1C);
    k = 0;
    while (!lcd_en && k < 200) begin @(posedge clk); k++; end
    check_val("en_seen", 32'(lcd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_en", 32'(lcd_en), 32'd0);
    check_val("midrst_on", 32'(lcd_on), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd1);
    do_reset(1'b0);
    model_char(8'h4B); send_code(8'h42); wait_idle();

    check_val("sb_final", sb.size(), 0);
    check_val("drop_total", drop_cnt, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
